pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller that drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC.
- Detects load-use hazards between ID and EX.
- Converts an EX-stage branch mispredict into a multi-cycle front-end flush.
- Freezes the whole pipeline while a data-memory access waits for its ready handshake, with a timeout guard.
- Sits beside the pipeline registers in the core top level.

Parameters:
FLUSH_CYCLES, 1, number of consecutive cycles IF/ID and ID/EX are flushed per mispredict (legal 1..4)
MEM_TIMEOUT, 16, MEM_WAIT cycles before the timeout is forced (legal 2..255)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
id_rs1  input  5  source reg 1 of instruction in ID
id_rs2  input  5  source reg 2 of instruction in ID
id_uses_rs1  input  1  ID instruction reads rs1
id_uses_rs2  input  1  ID instruction reads rs2
ex_wb_load  input  1  instruction in EX is a load
ex_wb_rd  input  5  destination reg of EX instruction
ex_mispredict  input  1  EX resolved a branch/jump against prediction
mem_req  input  1  MEM stage issuing a data-memory access this cycle
mem_ready  input  1  data memory completes access this cycle
pc_en  output  1  PC update enable
pc_redirect  output  1  select EX-corrected target for PC
if_id_en  output  1  IF/ID register enable
if_id_flush  output  1  IF/ID bubble insert
id_ex_en  output  1  ID/EX register enable
id_ex_flush  output  1  ID/EX bubble insert
ex_mem_en  output  1  EX/MEM register enable
mem_wb_en  output  1  MEM/WB register enable
mem_timeout  output  1  sticky: a memory wait hit MEM_TIMEOUT
stall_cycles  output  32  perf counter (see Optional Feature)
flush_events  output  32  perf counter (see Optional Feature)

Behaviour:
- Reset (asynchronous, while rst=1):
  - state=RUN, counters=0, mem_timeout=0.
  - All enables, flushes and pc_redirect=0.
- State register is clocked; outputs are combinational from state and inputs.
- load_use = ex_wb_load & (ex_wb_rd!=0) & ((id_uses_rs1 & id_rs1==ex_wb_rd) | (id_uses_rs2 & id_rs2==ex_wb_rd)).
- RUN, priority highest first:
  1. mem_req & !mem_ready:
     - All enables=0, flushes=0.
     - wait_cnt<=1, go MEM_WAIT.
  2. ex_mispredict:
     - pc_en=1, pc_redirect=1.
     - if_id_flush=1, id_ex_flush=1; if_id_en=id_ex_en=1.
     - ex_mem_en=mem_wb_en=1.
     - If FLUSH_CYCLES>1: flush_cnt<=FLUSH_CYCLES-1, go FLUSH.
  3. load_use:
     - pc_en=0, if_id_en=0.
     - id_ex_en=1, id_ex_flush=1 (one bubble).
     - ex_mem_en=mem_wb_en=1.
     - Stay RUN; the hazard clears the next cycle because the load moves to MEM.
  4. Otherwise: all enables=1, flushes=0, pc_redirect=0.
- MEM_WAIT:
  - All enables=0; wait_cnt increments each cycle.
  - mem_ready=1: outputs as RUN step 4 this cycle (pipeline advances), go RUN.
  - Else if wait_cnt==MEM_TIMEOUT-1: mem_timeout<=1, outputs as RUN step 4, go RUN.
  - ex_mispredict is ignored here; EX is frozen, so it stays asserted and is serviced in RUN.
- FLUSH:
  - pc_en=1, pc_redirect=0, if_id_flush=id_ex_flush=1.
  - All enables=1; flush_cnt decrements.
  - Go RUN when flush_cnt==1.
  - mem_req & !mem_ready takes priority: freeze and go MEM_WAIT; the remaining flush is dropped.
- mem_timeout is sticky and is cleared only by rst.
- Flush and enable asserted together means flush wins, per the pipeline-register contract.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined:
  - stall_cycles increments every cycle with pc_en=0 and !rst.
  - flush_events increments on each RUN-state mispredict acceptance.
  - Both are 32-bit and wrap at 2^32-1 to 0; both reset to 0.
- Undefined: both outputs are tied to 0 and no counter flops are synthesized.

Test Plan:
- Load-use: ex_wb_load=1, ex_wb_rd=5, id_rs1=5, id_uses_rs1=1 -> for exactly one cycle pc_en=0, if_id_en=0, id_ex_flush=1; normal flow next cycle. Repeat with ex_wb_rd=0 -> no stall.
- Mispredict, FLUSH_CYCLES=2: pulse ex_mispredict one cycle -> cycle0 pc_redirect=1 with both flushes; cycle1 flushes=1, pc_redirect=0; cycle2 flushes=0; flush_events=1.
- Memory wait: mem_req=1, mem_ready low for 3 cycles then high -> all enables 0 for 3 cycles, all 1 on the ready cycle, stall_cycles=3, mem_timeout=0.
- Timeout, MEM_TIMEOUT=4: mem_req=1, mem_ready never -> freeze for 3 cycles, mem_timeout=1 on the 4th edge and stays 1 until rst.
- Simultaneous events: mem_req & !mem_ready and ex_mispredict in the same RUN cycle -> freeze first; after mem_ready the mispredict flush occurs the next cycle.
- Reset mid-FLUSH: assert rst asynchronously -> outputs go to 0 immediately without waiting for a clock; after release state is RUN with no residual flush.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and pipeline_hazard_ctrl.
//
// The master modport is the pipeline side. It supplies the hazard sources and
// receives the stall and flush controls. The slave modport is the controller side.
//   id_rs1/id_rs2, id_uses_rs1/id_uses_rs2 : ID-stage source operands
//   ex_wb_load, ex_wb_rd                   : EX-stage load indication and destination
//   ex_mispredict                          : EX-stage branch/jump mispredict
//   mem_req, mem_ready                     : MEM-stage data-memory handshake
//   pc_en, pc_redirect                     : PC update enable and target select
//   if_id_en/flush, id_ex_en/flush         : front-end register controls
//   ex_mem_en, mem_wb_en                   : back-end register enables
//   mem_timeout                            : sticky memory-timeout flag
//   stall_cycles, flush_events             : performance counters
interface pipeline_hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic        ex_wb_load;
  logic [4:0]  ex_wb_rd;
  logic        ex_mispredict;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_en;
  logic        pc_redirect;
  logic        if_id_en;
  logic        if_id_flush;
  logic        id_ex_en;
  logic        id_ex_flush;
  logic        ex_mem_en;
  logic        mem_wb_en;
  logic        mem_timeout;
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_wb_load, ex_wb_rd,
           ex_mispredict, mem_req, mem_ready,
    input  pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_en, mem_wb_en, mem_timeout, stall_cycles, flush_events
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_wb_load, ex_wb_rd,
           ex_mispredict, mem_req, mem_ready,
    output pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_en, mem_wb_en, mem_timeout, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for a five-stage pipeline.
//
// This block generates the enable and flush controls for IF/ID, ID/EX, EX/MEM and MEM/WB,
// and the PC enable and redirect. It handles:
//   - load-use hazards, with a single bubble inserted into ID/EX;
//   - EX mispredicts, flushing IF/ID and ID/EX for FLUSH_CYCLES cycles;
//   - data-memory waits, freezing the whole pipeline until mem_ready or until
//     MEM_TIMEOUT cycles elapse. A timeout sets the sticky mem_timeout flag.
//
// Ports:
//   clk : clock (rising edge)
//   rst : asynchronous active-high reset. All outputs read 0 while rst is high.
//   bus : pipeline_hazard_ctrl_if.slave (see the interface file for the signals)
//
// Optional build macro PIPE_PERF_CNT_EN enables the stall_cycles and flush_events
// counters. Without it, both outputs are tied to 0.
module pipeline_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 16
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StRun, StMemWait, StFlush} state_e;

  localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [2:0] flush_cnt_q, flush_cnt_d;
  logic       timeout_q, timeout_d;

  logic load_use, mem_stall;
  logic pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic ex_mem_en, mem_wb_en;

  assign load_use = bus.ex_wb_load && (bus.ex_wb_rd != 5'd0) &&
                    ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_wb_rd)) ||
                     (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_wb_rd)));
  assign mem_stall = bus.mem_req && !bus.mem_ready;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    flush_cnt_d = flush_cnt_q;
    timeout_d   = timeout_q;
    // Default is a full freeze. Each branch below opens up what it needs.
    pc_en       = 1'b0;
    pc_redirect = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          wait_cnt_d = 8'd1;
          state_d    = StMemWait;
        end else if (bus.ex_mispredict) begin
          {pc_en, pc_redirect, if_id_en, if_id_flush} = 4'b1111;
          {id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en} = 4'b1111;
          if (FLUSH_CYCLES > 1) begin
            flush_cnt_d = 3'(FLUSH_CYCLES - 1);
            state_d     = StFlush;
          end
        end else if (load_use) begin
          // Hold PC and IF/ID, and send a bubble down ID/EX while the load advances.
          {id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en} = 4'b1111;
        end else begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
        end
      end
      StMemWait: begin
        wait_cnt_d = wait_cnt_q + 8'd1;
        if (bus.mem_ready || (wait_cnt_q == TimeoutLast)) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
          state_d = StRun;
          if (!bus.mem_ready) timeout_d = 1'b1;
        end
      end
      StFlush: begin
        if (mem_stall) begin
          // The memory freeze takes precedence. Any remaining flush cycles are dropped.
          wait_cnt_d = 8'd1;
          state_d    = StMemWait;
        end else begin
          {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush} = 5'b11111;
          {ex_mem_en, mem_wb_en} = 2'b11;
          flush_cnt_d = flush_cnt_q - 3'd1;
          if (flush_cnt_q == 3'd1) state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      wait_cnt_q  <= 8'd0;
      flush_cnt_q <= 3'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // The outputs are combinational, so they are gated by rst. This makes them fall
  // at once when reset is asserted, without waiting for a clock.
  assign bus.pc_en       = pc_en & ~rst;
  assign bus.pc_redirect = pc_redirect & ~rst;
  assign bus.if_id_en    = if_id_en & ~rst;
  assign bus.if_id_flush = if_id_flush & ~rst;
  assign bus.id_ex_en    = id_ex_en & ~rst;
  assign bus.id_ex_flush = id_ex_flush & ~rst;
  assign bus.ex_mem_en   = ex_mem_en & ~rst;
  assign bus.mem_wb_en   = mem_wb_en & ~rst;
  assign bus.mem_timeout = timeout_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_q, flush_ev_q;
  logic        misp_accept;

  assign misp_accept = (state_q == StRun) && !mem_stall && bus.ex_mispredict;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q    <= 32'd0;
      flush_ev_q <= 32'd0;
    end else begin
      if (!pc_en) stall_q <= stall_q + 32'd1;
      if (misp_accept) flush_ev_q <= flush_ev_q + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_q;
  assign bus.flush_events = flush_ev_q;
`else
  assign bus.stall_cycles = 32'd0;
  assign bus.flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl, built with FLUSH_CYCLES=2 and MEM_TIMEOUT=4.
// It runs fixed vectors, then hand-written multi-cycle sequences, then random stimulus
// checked against a behavioural model.
module tb_pipeline_hazard_ctrl;
  localparam int unsigned FlushCycles = 2;
  localparam int unsigned MemTimeout  = 4;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  // Output vector order: pc_en, pc_redirect, if_id_en, if_id_flush,
  //                      id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en
  localparam logic [7:0] Norm    = 8'b1010_1011;
  localparam logic [7:0] LoadUse = 8'b0000_1111;
  localparam logic [7:0] Misp    = 8'b1111_1111;
  localparam logic [7:0] FlushV  = 8'b1011_1111;
  localparam logic [7:0] Freeze  = 8'b0000_0000;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       load;
    logic [4:0] rd;
    logic       misp;
    logic       req;
    logic       rdy;
  } in_t;

  typedef struct packed {
    in_t        in;
    logic [7:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl #(
    .FLUSH_CYCLES(FlushCycles),
    .MEM_TIMEOUT (MemTimeout)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int tally_stalls  = 0;
  int tally_flushes = 0;

  // Behavioural model state: memory wait in progress and its age, pending flush cycles.
  bit m_wait;
  int m_wait_len;
  int m_flush_left;
  bit m_to;
  int m_stalls;
  int m_flushes;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dut_outs();
    return {bus.pc_en, bus.pc_redirect, bus.if_id_en, bus.if_id_flush,
            bus.id_ex_en, bus.id_ex_flush, bus.ex_mem_en, bus.mem_wb_en};
  endfunction

  function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                             input logic u2, input logic load, input logic [4:0] rd,
                             input logic misp, input logic req, input logic rdy);
    in_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.load = load; v.rd = rd;
    v.misp = misp; v.req = req; v.rdy = rdy;
    return v;
  endfunction

  task automatic apply(input in_t v);
    bus.id_rs1 = v.rs1;
    bus.id_rs2 = v.rs2;
    bus.id_uses_rs1 = v.u1;
    bus.id_uses_rs2 = v.u2;
    bus.ex_wb_load = v.load;
    bus.ex_wb_rd = v.rd;
    bus.ex_mispredict = v.misp;
    bus.mem_req = v.req;
    bus.mem_ready = v.rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check this cycle's outputs against constants, tally expected perf events, then advance.
  task automatic hand_step(input string name, input logic [7:0] exp);
    #2;
    check(name, 32'(dut_outs()), 32'(exp));
    if (!exp[7]) tally_stalls++;
    if (exp == Misp) tally_flushes++;
    tick();
  endtask

  task automatic check_counters(input string name);
    check({name, "_stalls"}, bus.stall_cycles, PerfEn ? 32'(tally_stalls) : 32'd0);
    check({name, "_flushes"}, bus.flush_events, PerfEn ? 32'(tally_flushes) : 32'd0);
  endtask

  // Reference behaviour for one cycle. It returns the expected outputs and advances the model.
  task automatic model_cycle(output logic [7:0] exp);
    bit stall;
    bit hazard;
    stall = bus.mem_req && !bus.mem_ready;
    hazard = 1'b0;
    if (bus.ex_wb_load && bus.ex_wb_rd != 5'd0) begin
      if (bus.id_uses_rs1 && bus.id_rs1 == bus.ex_wb_rd) hazard = 1'b1;
      if (bus.id_uses_rs2 && bus.id_rs2 == bus.ex_wb_rd) hazard = 1'b1;
    end
    if (m_wait) begin
      if (bus.mem_ready || m_wait_len == int'(MemTimeout) - 1) begin
        exp = Norm;
        if (!bus.mem_ready) m_to = 1'b1;
        m_wait = 1'b0;
      end else begin
        exp = Freeze;
        m_wait_len++;
      end
    end else if (m_flush_left > 0) begin
      if (stall) begin
        exp = Freeze;
        m_flush_left = 0;
        m_wait = 1'b1;
        m_wait_len = 1;
      end else begin
        exp = FlushV;
        m_flush_left--;
      end
    end else if (stall) begin
      exp = Freeze;
      m_wait = 1'b1;
      m_wait_len = 1;
    end else if (bus.ex_mispredict) begin
      exp = Misp;
      m_flush_left = int'(FlushCycles) - 1;
      m_flushes++;
    end else if (hazard) begin
      exp = LoadUse;
    end else begin
      exp = Norm;
    end
    if (!exp[7]) m_stalls++;
  endtask

  vec_t tbl[9];
  in_t  idle;

  initial begin
    idle = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tbl[0] = '{in: idle, exp: Norm};
    tbl[1] = '{in: mk(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0), exp: LoadUse};
    tbl[2] = '{in: mk(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0), exp: Norm};
    tbl[3] = '{in: mk(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0), exp: Norm};
    tbl[4] = '{in: mk(5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0), exp: LoadUse};
    tbl[5] = '{in: mk(5'd9, 5'd9, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0), exp: Norm};
    tbl[6] = '{in: mk(5'd4, 5'd6, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0), exp: Norm};
    tbl[7] = '{in: mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1), exp: Norm};
    tbl[8] = '{in: mk(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0), exp: Norm};

    // Reset state. The idle inputs would enable everything outside reset.
    rst = 1'b1;
    apply(idle);
    #3;
    check("reset_outs", 32'(dut_outs()), 32'd0);
    check("reset_timeout", 32'(bus.mem_timeout), 32'd0);
    check_counters("reset");
    tick();
    rst = 1'b0;

    // Single-cycle vectors from RUN.
    for (int i = 0; i < 9; i++) begin
      apply(tbl[i].in);
      hand_step($sformatf("tbl%0d", i), tbl[i].exp);
    end
    check_counters("after_tbl");

    // Mispredict with a two-cycle flush.
    apply(idle);
    bus.ex_mispredict = 1'b1;
    hand_step("misp_c0", Misp);
    bus.ex_mispredict = 1'b0;
    hand_step("misp_c1", FlushV);
    hand_step("misp_c2", Norm);
    check_counters("after_misp");

    // Memory wait: ready low for three cycles, then high.
    bus.mem_req = 1'b1;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) hand_step($sformatf("memwait_f%0d", i), Freeze);
    bus.mem_ready = 1'b1;
    hand_step("memwait_ready", Norm);
    apply(idle);
    check("memwait_no_timeout", 32'(bus.mem_timeout), 32'd0);
    check_counters("after_memwait");
    hand_step("memwait_after", Norm);

    // A memory stall and a mispredict in the same cycle: the freeze is handled first.
    bus.mem_req = 1'b1;
    bus.mem_ready = 1'b0;
    bus.ex_mispredict = 1'b1;
    hand_step("simul_freeze", Freeze);
    bus.mem_ready = 1'b1;
    hand_step("simul_ready", Norm);
    bus.mem_req = 1'b0;
    bus.mem_ready = 1'b0;
    hand_step("simul_misp", Misp);
    bus.ex_mispredict = 1'b0;
    hand_step("simul_flush", FlushV);
    hand_step("simul_norm", Norm);
    check_counters("after_simul");

    // Timeout: ready never arrives.
    bus.mem_req = 1'b1;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) hand_step($sformatf("to_f%0d", i), Freeze);
    check("to_not_yet", 32'(bus.mem_timeout), 32'd0);
    hand_step("to_release", Norm);
    check("to_set", 32'(bus.mem_timeout), 32'd1);
    apply(idle);
    hand_step("to_norm", Norm);
    hand_step("to_norm2", Norm);
    check("to_sticky", 32'(bus.mem_timeout), 32'd1);
    check_counters("after_to");

    // Reset asserted in the middle of FLUSH.
    bus.ex_mispredict = 1'b1;
    hand_step("rf_misp", Misp);
    bus.ex_mispredict = 1'b0;
    #2;
    check("rf_in_flush", 32'(dut_outs()), 32'(FlushV));
    rst = 1'b1;
    #1;
    check("rf_async_outs", 32'(dut_outs()), 32'd0);
    check("rf_async_timeout", 32'(bus.mem_timeout), 32'd0);
    tick();
    rst = 1'b0;
    tally_stalls = 0;
    tally_flushes = 0;
    check_counters("rf_cleared");
    hand_step("rf_no_residual", Norm);

    // Random stimulus against the model, starting from the post-reset state.
    m_wait = 1'b0;
    m_wait_len = 0;
    m_flush_left = 0;
    m_to = 1'b0;
    m_stalls = tally_stalls;
    m_flushes = 0;
    for (int i = 0; i < 400; i++) begin
      logic [7:0] exp;
      in_t v;
      check("rnd_timeout", 32'(bus.mem_timeout), 32'(m_to));
      check("rnd_stalls", bus.stall_cycles, PerfEn ? 32'(m_stalls) : 32'd0);
      check("rnd_flushes", bus.flush_events, PerfEn ? 32'(m_flushes) : 32'd0);
      v.rs1  = 5'($urandom_range(0, 3));
      v.rs2  = 5'($urandom_range(0, 3));
      v.u1   = 1'($urandom);
      v.u2   = 1'($urandom);
      v.load = 1'($urandom);
      v.rd   = 5'($urandom_range(0, 3));
      v.misp = ($urandom_range(0, 4) == 0);
      v.req  = ($urandom_range(0, 3) == 0);
      v.rdy  = 1'($urandom);
      apply(v);
      model_cycle(exp);
      #2;
      check($sformatf("rnd%0d", i), 32'(dut_outs()), 32'(exp));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
